// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: prescaled digit scan, hex decode,
// leading-zero blanking and per-digit blink, frame-synchronous value update.
// Outputs are registered one clock after the index/display state they show.
module seven_seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Scan state
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;

  // Pending (written by load) and display (shown this frame) registers
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;

  // Registered outputs
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tc;
  logic                  frame_end;
  logic [DIGITS-1:0]     lz_mask;
  logic                  all_zero;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;

  // Active-low g..a hex decode
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Prescaler, digit index, blink phase and pending/display register updates
  always_comb begin
    tc        = (presc_q == PRESC_LAST);
    frame_end = tc && (idx_q == IDX_LAST);

    presc_d = tc ? '0 : presc_q + PW'(1);

    idx_d = idx_q;
    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    frame_done_d = frame_end;

    // Last load in the frame wins
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp    : pend_dp_q;

    // Display only changes at the frame boundary so a frame never mixes loads;
    // a load landing exactly on the boundary bypasses pending.
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (frame_end) begin
      disp_val_d = load ? value : pend_val_q;
      disp_dp_d  = load ? dp    : pend_dp_q;
    end

    // Phase flips together with every BLINK_FRAMES-th frame_done pulse
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Leading-zero mask: bit i set when nibbles DIGITS-1 down to i are all zero
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (disp_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end
  end

  // Select current digit and form the next registered output pattern
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = (blank_lz & lz_mask[i]) | (phase_q & blink_en[i]);
        an_d[i]   = 1'b0;
      end
    end

    if (cur_blank) begin
      seg_d    = 7'b1111111;
      dp_out_d = 1'b1;
      an_d     = '1;
    end else begin
      seg_d    = hex7(cur_nib);
      dp_out_d = ~cur_dp;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= 7'b1111111;
      dp_out_q     <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_out_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// A timeline-based reference model is compared every cycle, plus literal
// frame patterns for a few hand-worked cases.
module tb_seven_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int SCAN_DIV = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FL = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .dp_out(dp_out),
    .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  hex_tab [16];
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  int          m_t;
  bit          m_valid = 0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
    hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
    hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
    hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
  end

  // m_t counts clocks since reset release; slot, frame and blink phase follow by arithmetic
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0;
      e_seg = 7'h7f; e_dp = 1'b1; e_an = 4'hf; e_fd = 1'b0;
      m_valid = 1;
    end else begin
      int  slot;
      int  frame;
      bit  blank;
      slot  = (m_t / SCAN_DIV) % DIGITS;
      frame = m_t / FL;
      blank = (blink_en[slot] && ((frame / BLINK_FRAMES) % 2 == 1)) ||
              (blank_lz && slot > 0 && ((m_disp >> (4 * slot)) == 16'h0));
      e_fd = ((m_t % FL) == FL - 1);
      if (blank) begin
        e_an = 4'hf; e_seg = 7'h7f; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'(1) << slot);
        e_seg = hex_tab[(m_disp >> (4 * slot)) & 16'hf];
        e_dp  = ~m_ddp[slot];
      end
      if ((m_t % FL) == FL - 1) begin
        m_disp = load ? value : m_pend;
        m_ddp  = load ? dp_in : m_pdp;
      end
      if (load) begin
        m_pend = value;
        m_pdp  = dp_in;
      end
      m_t++;
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_seg", 32'(seg), 32'(e_seg));
      chk("m_dp_out", 32'(dp_out), 32'(e_dp));
      chk("m_an", 32'(an), 32'(e_an));
      chk("m_frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  // ---------------- directed helpers ----------------
  // Reset, then load v/d on the first clock out of reset; returns at the
  // negedge showing the t=0 outputs (digit 0 always visible there).
  task automatic reset_and_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_dp_out", 32'(dp_out), 32'h1);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0; load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
    chk("first_an", 32'(an), 32'he);
    chk("first_seg", 32'(seg), 32'h40);
  endtask

  // Waits n negedges to the frame_done of frame 0, then checks frame 1 slot by slot
  task automatic check_frame1(input int n, input logic [15:0] an_tab,
                              input logic [27:0] seg_tab, input logic [3:0] dpo_tab);
    repeat (n) @(negedge clk);
    chk("frame_done_pulse", 32'(frame_done), 32'h1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("lit_an", 32'(an), 32'(an_tab[4*s +: 4]));
        chk("lit_seg", 32'(seg), 32'(seg_tab[7*s +: 7]));
        chk("lit_dp_out", 32'(dp_out), 32'(dpo_tab[s]));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] mask;
    // Hex pattern 12AF
    blank_lz = 1'b0; blink_en = 4'h0;
    reset_and_load(16'h12AF, 4'h0);
    check_frame1(15, 16'b0111_1011_1101_1110,
                 {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111);

    // Leading-zero blanking
    blank_lz = 1'b1;
    reset_and_load(16'h0042, 4'h0);
    check_frame1(15, 16'b1111_1111_1101_1110,
                 {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100}, 4'b1111);
    reset_and_load(16'h0000, 4'h0);
    check_frame1(15, 16'b1111_1111_1111_1110,
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111);
    blank_lz = 1'b0;

    // Two loads in frame 0: frame 1 shows only the last
    reset_and_load(16'h0000, 4'h0);
    @(negedge clk); @(negedge clk);
    load = 1'b1; value = 16'h1111;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk); @(negedge clk);
    load = 1'b1; value = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    check_frame1(9, 16'b0111_1011_1101_1110,
                 {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}, 4'b1111);

    // Decimal point on digit 2, then reset at clock 6 of a frame
    reset_and_load(16'h3210, 4'b0100);
    check_frame1(15, 16'b0111_1011_1101_1110,
                 {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}, 4'b1011);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", 32'(an), 32'hf);
    chk("midrst_seg", 32'(seg), 32'h7f);
    chk("midrst_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_disp0", 32'(seg), 32'h40);

    // Blink: digit 0 visible frames 0-1, blanked 2-3, visible 4
    blink_en = 4'b0001;
    reset_and_load(16'h0005, 4'h0);
    repeat (16) @(negedge clk);
    chk("blink_f1", 32'(an), 32'he);
    repeat (16) @(negedge clk);
    chk("blink_f2", 32'(an), 32'hf);
    repeat (16) @(negedge clk);
    chk("blink_f3", 32'(an), 32'hf);
    repeat (16) @(negedge clk);
    chk("blink_f4", 32'(an), 32'he);
    chk("blink_f4_seg", 32'(seg), 32'b0010010);

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 599) == 0);
      load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: mask = 16'hffff;
        1: mask = 16'h0fff;
        2: mask = 16'h00ff;
        3: mask = 16'h000f;
        default: mask = 16'h0000;
      endcase
      value = 16'($urandom) & mask;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 99) == 0) blink_en = 4'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter SCAN_DIV, default 50000, clocks per digit slot (>=2).
REQ-003 Parameter BLINK_FRAMES, default 64, full frames per blink half-period (>=1).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-007 dp  input  DIGITS  decimal point request per digit, 1 = lit.
REQ-008 load  input  1  one-cycle strobe; captures value/dp into the pending register.
REQ-009 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-010 blink_en  input  DIGITS  1 = digit blinks.
REQ-011 seg  output  7  segments g..a (bit6=g, bit0=a), active-low, registered.
REQ-012 dp_out  output  1  decimal point, active-low, registered.
REQ-013 an  output  DIGITS  digit enables, active-low, exactly one low at a time or all high, registered.
REQ-014 frame_done  output  1  one-cycle pulse when last digit slot ends.

Function
REQ-015 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; terminal count (tc) asserts when prescaler = SCAN_DIV-1.
REQ-016 Digit index SHALL advance on tc, DIGITS-1 wraps to 0; frame_done SHALL pulse in the cycle after tc at index DIGITS-1.
REQ-017 load SHALL copy value/dp into pending register on the clock edge it is high; multiple loads in a frame: last one wins.
REQ-018 Pending SHALL transfer to display register on the tc that wraps index to 0 (frame boundary); digits never show a mix of two loads within one frame.
REQ-019 load coinciding with the frame-boundary tc SHALL write value/dp directly to both pending and display registers.
REQ-020 Hex decode (active-low, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-021 Digit i (i>0) SHALL be blanked when blank_lz=1 and display nibbles DIGITS-1 down to i are all zero; digit 0 is never LZ-blanked; dp of a blanked digit is suppressed.
REQ-022 Blink phase SHALL toggle every BLINK_FRAMES frame_done pulses; phase=1 with blink_en[i]=1 blanks digit i.
REQ-023 Blanked digit: seg=1111111, dp_out=1, an all high for that slot.
REQ-024 Non-blanked digit: an[index]=0 (others 1), seg=decode(nibble), dp_out=~dp[index].
REQ-025 Outputs SHALL reflect index/display state with exactly one clock of latency.
REQ-026 blank_lz and blink_en are sampled live (not via pending) and take effect next cycle.

Reset
REQ-027 rst=1 SHALL force: an all 1, seg=1111111, dp_out=1, frame_done=0, prescaler=0, index=0, pending=0, display=0, blink phase=0.
REQ-028 rst asserted mid-frame SHALL abort the frame; no frame_done and no pending transfer on that edge.
REQ-029 First cycle after rst deasserts: outputs still reset values; second cycle: digit 0 driven showing 0 (display=0).

Verification (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-030 Reset, load value=16'h12AF dp=0000, wait one frame -> per slot of 4 clocks: an=1110 seg=0001110, an=1101 seg=0001000, an=1011 seg=0100100, an=0111 seg=1111001.
REQ-031 load 16'h0042 with blank_lz=1 -> digits 3,2 an all high/seg 1111111; digit 1 seg=0011001; digit 0 seg=0100100; value 16'h0000 -> only digit 0 lit showing 1000000.
REQ-032 load 16'h1111 mid-frame then 16'h2222 same frame -> current frame unchanged, next frame all digits 0100100; no 1111001 appears.
REQ-033 blink_en=0001 -> digit 0 visible frames 0-1, blanked frames 2-3, visible frames 4-5; frame_done one pulse per 16 clocks.
REQ-034 dp=0100, value 16'h3210 -> dp_out=0 only in digit-2 slot; rst asserted at clock 6 of frame -> next cycle all outputs reset values, display=0.
